// File: rtl/game_pkg.sv
// game_pkg: shared direction/state types and direction helper for the sprite mover
package game_pkg;
  typedef enum logic [1:0] {UP = 2'b00, RIGHT = 2'b01, DOWN = 2'b10, LEFT = 2'b11} dir_t;
  typedef enum logic [1:0] {IDLE, CHK_TURN, CHK_AHEAD, STEP} state_t;
  localparam int TILES_Y = 60;
  function automatic dir_t opposite(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction
endpackage

// File: rtl/tile_neighbor.sv
// tile_neighbor: neighbour tile and one-pixel step with horizontal tunnel wrap
module tile_neighbor import game_pkg::*; #(
  parameter int         TILE_LOG2 = 3,
  parameter logic [9:0] WRAP_MIN  = 10'd0,
  parameter logic [9:0] WRAP_MAX  = 10'd632
) (
  input  logic [9:0] i_pos_x,
  input  logic [9:0] i_pos_y,
  input  dir_t       i_dir,
  output logic [6:0] o_tx,
  output logic [5:0] o_ty,
  output logic [9:0] o_nx,
  output logic [9:0] o_ny
);
  localparam logic [6:0] TX_MIN = 7'(WRAP_MIN >> TILE_LOG2);
  localparam logic [6:0] TX_MAX = 7'(WRAP_MAX >> TILE_LOG2);
  localparam logic [5:0] TY_MAX = 6'(TILES_Y - 1);
  logic [6:0] w_tx;
  logic [5:0] w_ty;
  // tile one step away in i_dir and the pixel position one step away, both wrapping
  always_comb begin
    w_tx = 7'(i_pos_x >> TILE_LOG2);
    w_ty = 6'(i_pos_y >> TILE_LOG2);
    o_tx = i_dir == RIGHT ? (w_tx == TX_MAX ? TX_MIN : w_tx + 7'd1) :
           i_dir == LEFT  ? (w_tx == TX_MIN ? TX_MAX : w_tx - 7'd1) : w_tx;
    o_ty = i_dir == DOWN ? (w_ty == TY_MAX ? 6'd0 : w_ty + 6'd1) :
           i_dir == UP   ? (w_ty == 6'd0 ? TY_MAX : w_ty - 6'd1) : w_ty;
    o_nx = i_dir == RIGHT ? (i_pos_x == WRAP_MAX ? WRAP_MIN : i_pos_x + 10'd1) :
           i_dir == LEFT  ? (i_pos_x == WRAP_MIN ? WRAP_MAX : i_pos_x - 10'd1) : i_pos_x;
    o_ny = i_dir == DOWN ? i_pos_y + 10'd1 : i_dir == UP ? i_pos_y - 10'd1 : i_pos_y;
  end
endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: frame-paced maze sprite movement with buffered turns and wall queries
module sprite_mover import game_pkg::*; #(
  parameter logic [9:0] START_X   = 10'd320,
  parameter logic [9:0] START_Y   = 10'd240,
  parameter int         SPEED     = 1,
  parameter int         TILE_LOG2 = 3,
  parameter logic [9:0] WRAP_MIN  = 10'd0,
  parameter logic [9:0] WRAP_MAX  = 10'd632
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [2:0] direction,
  output logic       wall_req,
  output logic [6:0] wall_tx,
  output logic [5:0] wall_ty,
  input  logic       wall_ack,
  input  logic       wall_hit,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic [1:0] cur_dir,
  output logic       moving,
  output logic       frame_overrun
);
  logic       r_fc, r_fc_d, r_edge;
  state_t     r_state;
  dir_t       r_dir, r_pend, r_qdir;
  logic       r_pend_v, r_req, r_mov, r_ovr;
  logic [6:0] r_tx;
  logic [5:0] r_ty;
  logic [9:0] r_x, r_y;
  logic [2:0] r_cnt;
  dir_t       w_qdir;
  logic       w_aligned;
  logic [6:0] w_ntx;
  logic [5:0] w_nty;
  logic [9:0] w_nx, w_ny;

  assign w_aligned = r_x[TILE_LOG2-1:0] == '0 && r_y[TILE_LOG2-1:0] == '0;
  assign w_qdir = r_state == CHK_TURN ? r_pend : r_dir;

  tile_neighbor #(.TILE_LOG2(TILE_LOG2), .WRAP_MIN(WRAP_MIN), .WRAP_MAX(WRAP_MAX)) u_nb (
    .i_pos_x(r_x), .i_pos_y(r_y), .i_dir(w_qdir),
    .o_tx(w_ntx), .o_ty(w_nty), .o_nx(w_nx), .o_ny(w_ny)
  );

  // synchronise frame_clk and turn its rising edge into a one-cycle pulse
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fc <= 1'b0;
      r_fc_d <= 1'b0;
      r_edge <= 1'b0;
    end else begin
      r_fc <= frame_clk;
      r_fc_d <= r_fc;
      r_edge <= r_fc & ~r_fc_d;
    end
  end

  // per-frame movement sequencer: turn check, ahead check, then SPEED single-pixel steps
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_x <= START_X;
      r_y <= START_Y;
      r_dir <= LEFT;
      r_pend <= LEFT;
      r_qdir <= LEFT;
      r_pend_v <= 1'b0;
      r_mov <= 1'b0;
      r_req <= 1'b0;
      r_tx <= '0;
      r_ty <= '0;
      r_cnt <= '0;
      r_ovr <= 1'b0;
    end else begin
      r_ovr <= r_edge && r_state != IDLE;
      if (direction[2]) begin
        r_pend <= dir_t'(direction[1:0]);
        r_pend_v <= 1'b1;
      end
      case (r_state)
        IDLE: if (r_edge) begin
          r_cnt <= 3'(SPEED);
          r_state <= CHK_TURN;
        end
        CHK_TURN: if (r_req) begin
          if (wall_ack) begin
            r_req <= 1'b0;
            r_state <= CHK_AHEAD;
            if (!wall_hit) begin
              r_dir <= r_qdir;
              if (!direction[2]) r_pend_v <= 1'b0;
            end
          end
        end else if (r_pend_v && r_pend == opposite(r_dir)) begin
          r_dir <= r_pend;
          if (!direction[2]) r_pend_v <= 1'b0;
          r_state <= CHK_AHEAD;
        end else if (r_pend_v && w_aligned) begin
          r_req <= 1'b1;
          r_tx <= w_ntx;
          r_ty <= w_nty;
          r_qdir <= r_pend;
        end else begin
          r_state <= CHK_AHEAD;
        end
        CHK_AHEAD: if (r_req) begin
          if (wall_ack) begin
            r_req <= 1'b0;
            r_mov <= !wall_hit;
            r_state <= wall_hit ? IDLE : STEP;
            if (wall_hit) r_cnt <= '0;
          end
        end else if (w_aligned) begin
          r_req <= 1'b1;
          r_tx <= w_ntx;
          r_ty <= w_nty;
        end else begin
          r_mov <= 1'b1;
          r_state <= STEP;
        end
        STEP: begin
          r_x <= w_nx;
          r_y <= w_ny;
          r_cnt <= r_cnt - 3'd1;
          r_state <= r_cnt == 3'd1 ? IDLE : CHK_TURN;
        end
      endcase
    end
  end

  assign wall_req = r_req;
  assign wall_tx = r_tx;
  assign wall_ty = r_ty;
  assign pos_x = r_x;
  assign pos_y = r_y;
  assign cur_dir = r_dir;
  assign moving = r_mov;
  assign frame_overrun = r_ovr;
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: scoreboard bench for frame results, wall queries and tunnel wrap
module tb_sprite_mover;
  import game_pkg::*;
  typedef struct packed {logic [9:0] x; logic [9:0] y; logic [1:0] d; logic m;} res_t;

  logic Clk = 0, Reset = 1, frame_clk = 0, wall_ack = 0, wall_hit = 0;
  logic [2:0] direction = 3'b000;
  logic wall_req, moving, frame_overrun;
  logic [6:0] wall_tx;
  logic [5:0] wall_ty;
  logic [9:0] pos_x, pos_y;
  logic [1:0] cur_dir;
  logic Reset2 = 1, frame_clk2 = 0;
  logic wall_req2, moving2, ovr2;
  logic [6:0] wall_tx2;
  logic [5:0] wall_ty2;
  logic [9:0] pos_x2, pos_y2;
  logic [1:0] cur_dir2;

  int tests = 0, fails = 0, done_cnt = 0, ovr_cnt = 0, ack_delay = 0;
  logic wall_en = 0;
  res_t exp_res[$];
  logic [12:0] exp_q[$];
  logic [9:0] exp_x2[$];

  always #5 Clk = ~Clk;

  sprite_mover dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .direction(direction),
    .wall_req(wall_req), .wall_tx(wall_tx), .wall_ty(wall_ty),
    .wall_ack(wall_ack), .wall_hit(wall_hit), .pos_x(pos_x), .pos_y(pos_y),
    .cur_dir(cur_dir), .moving(moving), .frame_overrun(frame_overrun)
  );

  sprite_mover #(.START_X(10'd0), .SPEED(2)) dut2 (
    .Clk(Clk), .Reset(Reset2), .frame_clk(frame_clk2), .direction(3'b000),
    .wall_req(wall_req2), .wall_tx(wall_tx2), .wall_ty(wall_ty2),
    .wall_ack(wall_req2), .wall_hit(1'b0), .pos_x(pos_x2), .pos_y(pos_y2),
    .cur_dir(cur_dir2), .moving(moving2), .frame_overrun(ovr2)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_res(input int x, input int y, input int d, input int m);
    exp_res.push_back({10'(x), 10'(y), 2'(d), 1'(m)});
  endtask

  task automatic push_q(input int tx, input int ty);
    exp_q.push_back({7'(tx), 6'(ty)});
  endtask

  // wall map responder: single wall at tile (39,30) when enabled
  initial forever begin
    @(negedge Clk);
    if (wall_req) begin
      repeat (ack_delay) @(negedge Clk);
      wall_ack = 1;
      wall_hit = wall_en && wall_tx == 7'd39 && wall_ty == 6'd30;
      @(negedge Clk);
      wall_ack = 0;
      wall_hit = 0;
    end
  end

  // frame-result monitor: a return to IDLE marks the end of one frame's work
  initial begin
    state_t prev_st = IDLE;
    res_t r;
    forever begin
      @(negedge Clk);
      if (Reset) prev_st = IDLE;
      else begin
        if (prev_st != IDLE && dut.r_state == IDLE) begin
          done_cnt++;
          tests++;
          if (exp_res.size() == 0) begin
            fails++;
            $display("FAIL frame_result: unexpected completion x=%0d y=%0d dir=%0d moving=%0d", pos_x, pos_y, cur_dir, moving);
          end else begin
            r = exp_res.pop_front();
            if ({pos_x, pos_y, cur_dir, moving} !== r) begin
              fails++;
              $display("FAIL frame_result: got x=%0d y=%0d dir=%0d moving=%0d, required x=%0d y=%0d dir=%0d moving=%0d",
                       pos_x, pos_y, cur_dir, moving, r.x, r.y, r.d, r.m);
            end
          end
        end
        prev_st = dut.r_state;
      end
      if (frame_overrun) ovr_cnt++;
    end
  end

  // query monitor: every new wall_req must match the next expected tile
  initial begin
    logic prev_req = 0;
    logic [12:0] e;
    forever begin
      @(negedge Clk);
      if (wall_req && !prev_req) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL wall_query: unexpected tx=%0d ty=%0d, required none", wall_tx, wall_ty);
        end else begin
          e = exp_q.pop_front();
          if ({wall_tx, wall_ty} !== e) begin
            fails++;
            $display("FAIL wall_query: got tx=%0d ty=%0d, required tx=%0d ty=%0d", wall_tx, wall_ty, e[12:6], e[5:0]);
          end
        end
      end
      prev_req = wall_req;
    end
  end

  // wrap monitor for the SPEED=2 instance: each x change must follow the expected path
  initial begin
    logic [9:0] prev_x2 = 0;
    logic [9:0] e;
    forever begin
      @(negedge Clk);
      if (Reset2) prev_x2 = pos_x2;
      else if (pos_x2 != prev_x2) begin
        tests++;
        if (exp_x2.size() == 0) begin
          fails++;
          $display("FAIL wrap_x: unexpected x=%0d, required none", pos_x2);
        end else begin
          e = exp_x2.pop_front();
          if (pos_x2 !== e) begin
            fails++;
            $display("FAIL wrap_x: got x=%0d, required x=%0d", pos_x2, e);
          end
        end
        prev_x2 = pos_x2;
      end
    end
  end

  task automatic frame_only();
    frame_clk = 1;
    repeat (3) @(negedge Clk);
    frame_clk = 0;
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 200) begin
      @(negedge Clk);
      n++;
    end
    if (done_cnt == d0) begin
      tests++;
      fails++;
      $display("FAIL frame_timeout: got no completion, required one within 200 cycles");
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic frame();
    int d0 = done_cnt;
    frame_only();
    wait_done(d0);
  endtask

  task automatic wait_req();
    int n = 0;
    while (!wall_req && n < 50) begin
      @(negedge Clk);
      n++;
    end
    if (!wall_req) begin
      tests++;
      fails++;
      $display("FAIL req_timeout: got wall_req=0, required 1 within 50 cycles");
    end
  endtask

  task automatic dir_pulse(input logic [2:0] d);
    direction = d;
    @(negedge Clk);
    direction = 3'b000;
    @(negedge Clk);
  endtask

  task automatic do_reset();
    Reset = 1;
    repeat (2) @(negedge Clk);
    Reset = 0;
    @(negedge Clk);
  endtask

  initial begin
    int d0, o0;
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, o0;
    repeat (2) @(negedge Clk);
    Reset = 0;
    Reset2 = 0;
    @(negedge Clk);
    check("rst_pos_x", pos_x, 320);
    check("rst_pos_y", pos_y, 240);
    check("rst_cur_dir", cur_dir, 3);
    check("rst_moving", moving, 0);
    check("rst_wall_req", wall_req, 0);
    check("rst_overrun", frame_overrun, 0);
    // tunnel wrap at SPEED=2: 0 -> 632 -> 631 within one frame
    exp_x2.push_back(10'd632);
    exp_x2.push_back(10'd631);
    frame_clk2 = 1;
    repeat (3) @(negedge Clk);
    frame_clk2 = 0;
    repeat (40) @(negedge Clk);
    check("wrap_done", exp_x2.size(), 0);
    check("wrap_y", pos_y2, 240);
    check("wrap_dir", cur_dir2, 3);
    check("wrap_moving", moving2, 1);
    check("wrap_last_tx", wall_tx2, 78);
    check("wrap_last_ty", wall_ty2, 30);
    check("wrap_overrun", ovr2, 0);
    // wall directly to the left at reset position stops the sprite
    wall_en = 1;
    push_q(39, 30);
    push_res(320, 240, 3, 0);
    frame();
    // reverse out of the stop: no turn query, ahead query to the right
    dir_pulse(3'b101);
    push_q(41, 30);
    push_res(321, 240, 1, 1);
    frame();
    // free run left for three frames
    wall_en = 0;
    do_reset();
    push_q(39, 30);
    push_res(319, 240, 3, 1);
    frame();
    push_res(318, 240, 3, 1);
    frame();
    push_res(317, 240, 3, 1);
    frame();
    // reversals while unaligned take effect without any query
    dir_pulse(3'b101);
    push_res(318, 240, 1, 1);
    frame();
    dir_pulse(3'b111);
    push_res(317, 240, 3, 1);
    frame();
    // buffered up-turn waits for alignment at x=312
    dir_pulse(3'b100);
    for (int x = 316; x >= 312; x--) begin
      push_res(x, 240, 3, 1);
      frame();
    end
    push_q(39, 29);
    push_q(39, 29);
    push_res(312, 239, 0, 1);
    frame();
    // slow ack with a second frame edge arriving during the wait
    do_reset();
    ack_delay = 5;
    push_q(39, 30);
    push_res(319, 240, 3, 1);
    d0 = done_cnt;
    o0 = ovr_cnt;
    frame_only();
    wait_req();
    frame_only();
    wait_done(d0);
    check("overrun_pulses", ovr_cnt - o0, 1);
    // reset in the middle of a slow query
    do_reset();
    push_q(39, 30);
    frame_only();
    wait_req();
    Reset = 1;
    @(negedge Clk);
    check("midwait_req_drop", wall_req, 0);
    @(negedge Clk);
    Reset = 0;
    repeat (12) @(negedge Clk);
    check("late_ack_x", pos_x, 320);
    check("late_ack_moving", moving, 0);
    check("late_ack_req", wall_req, 0);
    ack_delay = 0;
    push_q(39, 30);
    push_res(319, 240, 3, 1);
    frame();
    check("res_queue_empty", exp_res.size(), 0);
    check("query_queue_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
